// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle, WIDTH/DIGIT cycles per sum.
// SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
//
// state | meaning
// IDLE  | ready for operands, no result held
// RUN   | one digit added per cycle, LSB digit first
// DONE  | result valid and held until out_ready
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_cout;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic                   dig_c_top;
    logic                   ovf_q;
`endif

    // Ripple of full-adder cells across the current digit
    always_comb begin
        logic c;
        c       = carry_q;
        dig_sum = '0;
`ifdef SERIAL_ADDER_OVF_EN
        dig_c_top = 1'b0;
`endif
        for (int i = 0; i < DIGIT; i++) begin
            dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
`ifdef SERIAL_ADDER_OVF_EN
            if (i == DIGIT - 1) dig_c_top = c;
`endif
            c = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        dig_cout = c;
    end

    // New digit enters at the MSB end; slicing the concatenation also covers DIGIT == WIDTH
    assign sum_cat = {dig_sum, sum_q};
    assign sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_d;
                    carry_q <= dig_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= dig_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q       <= dig_c_top ^ dig_cout;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (16/4 main instance, 8/8 single-digit instance).
// Honours SERIAL_ADDER_OVF_EN by also checking ovf.
module tb_serial_adder;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(8)) bus8 ();

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] low;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = low[W-1] ^ full[W];
        return e;
    endfunction

    // Monitor: push on accept, pop on result handshake, check latency/hold/ready
    logic         pv = 1'b0;
    logic         phs = 1'b0;
    logic         busy = 1'b0;
    logic [W-1:0] psum;
    logic         pc;
    int           acc_edge = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv   = 1'b0;
            phs  = 1'b0;
            busy = 1'b0;
            sb_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bus.a, bus.b, bus.cin));
                acc_edge = cyc + 1;
                busy     = 1'b1;
            end else if (busy && !bus.out_valid) begin
                check("rdy_run", bus.in_ready, 0);
            end
            if (bus.out_valid) begin
                busy = 1'b0;
                check("rdy_done", bus.in_ready, 0);
                if (!pv) begin
                    check("latency", cyc - acc_edge, NDIG);
                end else if (!phs) begin
                    check("hold_sum", bus.sum, psum);
                    check("hold_cout", bus.cout, pc);
                end
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("extra_out", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sum", bus.sum, e.s);
                        check("cout", bus.cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                        check("ovf", bus.ovf, e.o);
`endif
                    end
                end
            end
            pv   = bus.out_valid;
            phs  = bus.out_valid && bus.out_ready;
            psum = bus.sum;
            pc   = bus.cout;
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n = 0;
        bus.a = x;
        bus.b = y;
        bus.cin = c;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic rand_on = 1'b0;
    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus8.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        rst = 1'b0;

        // Single-digit instance: one RUN cycle
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        bus8.cin = 1'b1;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'h00;
        @(negedge clk);
        check("w8_run_valid", bus8.out_valid, 0);
        @(negedge clk);
        check("w8_valid", bus8.out_valid, 1);
        check("w8_sum", bus8.sum, 8'hFF);
        check("w8_cout", bus8.cout, 1);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0001, 1'b0);
        drain();

        // Result held while out_ready stays low
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_valid", bus.out_valid, 1);
        check("stall_sum", bus.sum, 16'h5556);
        check("stall_cout", bus.cout, 0);
        repeat (5) @(posedge clk);
        #1;
        check("stall_sum_late", bus.sum, 16'h5556);
        bus.out_ready = 1'b1;
        send(16'h8001, 16'h7FFF, 1'b0);
        drain();
`ifdef SERIAL_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0);
        drain();
`endif

        // Abort in the second RUN cycle
        send(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_sum", bus.sum, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_valid", bus.out_valid, 0);
        send(16'h0003, 16'h0004, 1'b0);
        drain();
        check("fresh_sum", bus.sum, 16'h0007);

        rand_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom));
        end
        rand_on = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal values are 1 or greater.
REQ-002 Parameter DIGIT, default 4: bits added per cycle; legal values are 1 to WIDTH, and WIDTH mod DIGIT shall be 0.
REQ-003 Derived constant NDIG = WIDTH/DIGIT: digit steps per operation.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand set a/b/cin presented.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in to bit 0.
REQ-011 out_valid  output  1  sum/cout valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-015 FSM states: IDLE, RUN, DONE; exactly one state is active at any time.
REQ-016 IDLE: in_ready=1, out_valid=0; if in_valid=1, capture a, b, cin, clear the digit counter, and go to RUN.
REQ-017 RUN: each cycle add the low DIGIT bits of the A and B shift registers plus the carry register with a DIGIT-bit ripple of full-adder cells, shift the result digit into sum from the MSB end, shift A and B right by DIGIT, register the digit carry, and increment the counter.
REQ-018 RUN exit: the cycle that processes digit NDIG-1 shall transition to DONE; in_ready=0 throughout RUN, and in_valid is ignored.
REQ-019 Latency: out_valid rises exactly NDIG cycles after the accepting edge (in_valid & in_ready).
REQ-020 DONE: out_valid=1; sum and cout shall be held stable until out_ready=1, then go to IDLE.
REQ-021 In DONE, in_ready=0; an in_valid arriving while out_ready=1 shall not be accepted until the following IDLE cycle (minimum issue interval NDIG+2 cycles).
REQ-022 out_ready asserted outside DONE shall have no effect.
REQ-023 DIGIT=WIDTH (NDIG=1) shall work: one RUN cycle.
REQ-024 Operands changing after acceptance shall not affect the result.
REQ-025 cout equals bit WIDTH of the full-precision (WIDTH+1)-bit sum a+b+cin.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, sum=0, cout=0, out_valid=0, counter/carry/shift registers=0; in_ready=1 from the following cycle.
REQ-027 rst during RUN or DONE shall abort the operation; no result shall be emitted for it.
REQ-028 rst shall take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-029 Macro SERIAL_ADDER_OVF_EN defined: add output port ovf (1 bit) = carry into bit WIDTH-1 XOR cout, valid with out_valid and held like sum; reset to 0.
REQ-030 Macro undefined: ovf port and its logic shall be absent; all other behaviour identical.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept, sum=0x0000, cout=1.
REQ-032 a=0x1234, b=0x4321, cin=1, out_ready held 0 for 5 cycles -> sum=0x5556, cout=0, held stable; in_ready=0 until the cycle after out_ready=1.
REQ-033 Start a=0xAAAA, b=0x5555; assert rst in 2nd RUN cycle -> out_valid never rises, sum=0, in_ready=1 the next cycle; a fresh 0x0003+0x0004 -> 0x0007.
REQ-034 With SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; 0xFFFF+0x0001 -> ovf=0.
REQ-035 WIDTH=8, DIGIT=8: 0xFF+0xFF+cin=1 -> sum=0xFF, cout=1, 1-cycle latency.
REQ-036 Randomised back-to-back stream of 1000 operations against a reference a+b+cin model, with out_ready toggling randomly -> zero mismatches, no lost or duplicated results.
